// File: rtl/sobel_pkg.sv
// Shared types for the Sobel frame sequencer and its helpers.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sobel_valid_delay.sv
// Clearable shift register carrying the (valid, row index) tag alongside the filter pipeline.
module sobel_valid_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] tag_in,
  output logic [W-1:0] tag_out
);

  logic [W-1:0] pipe [DEPTH];

  // Shift the tag one stage per clock; clr flushes every stage so a cancelled frame leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Frame controller: streams SIZE rows from frame RAM into the Sobel filter and writes SIZE-2 result rows.
//
//  state | meaning
//  IDLE  | waiting for start
//  READ  | issuing one row read per clock, rows 0..SIZE-1
//  DRAIN | reads finished, waiting for the last filtered row to be written
//  DONE  | one-cycle done pulse, then back to IDLE
module sobel_frame_sequencer #(
  parameter int SIZE     = 100,
  parameter int PIX_W    = sobel_pkg::PIX_W,
  parameter int FILT_LAT = 3,
  parameter int ADDR_W   = $clog2(SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [SIZE*PIX_W-1:0]     rd_data,
  output logic [SIZE*PIX_W-1:0]     filt_row,
  input  logic [(SIZE-2)*PIX_W-1:0] filt_out,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [(SIZE-2)*PIX_W-1:0] wr_data
);

  import sobel_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(SIZE - 1);
  localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(SIZE - 3);
  localparam logic [ADDR_W-1:0] FIRST_OUT_ROW = ADDR_W'(2);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q;
  logic [ADDR_W-1:0] rd_row_q;
  logic              rd_ret_q;
  logic [ADDR_W:0]   tag_q;
  logic [ADDR_W:0]   tag_out;
  logic              kill;
  logic              last_wr;

  assign kill    = abort && (state_q != IDLE);
  assign last_wr = wr_en && (wr_addr == LAST_WR);

  // Next-state logic; an abort in any active state overrides everything, including start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (rd_cnt_q == LAST_RD) state_d = DRAIN;
      DRAIN:   if (last_wr) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Read row counter: restarts on an accepted start, saturates at the last row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         rd_cnt_q <= '0;
    else if (kill)                                   rd_cnt_q <= '0;
    else if (state_q == IDLE && start)               rd_cnt_q <= '0;
    else if (state_q == READ && rd_cnt_q != LAST_RD) rd_cnt_q <= rd_cnt_q + 1'b1;
  end

  // Remember which read is returning this cycle (RAM has one cycle of latency).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ret_q <= 1'b0;
      rd_row_q <= '0;
    end else begin
      rd_ret_q <= rd_en && !kill;
      rd_row_q <= rd_cnt_q;
    end
  end

  // Capture the returning row for the filter; holds between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           filt_row <= '0;
    else if (rd_ret_q) filt_row <= rd_data;
  end

  // Tag launched alongside row r>=2 reaching filt_row; it names output row r-2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else if (kill) begin
      tag_q <= '0;
    end else if (rd_ret_q && rd_row_q >= FIRST_OUT_ROW) begin
      tag_q <= {1'b1, rd_row_q - FIRST_OUT_ROW};
    end else begin
      tag_q <= '0;
    end
  end

  sobel_valid_delay #(
    .DEPTH (FILT_LAT),
    .W     (ADDR_W + 1)
  ) u_valid_delay (
    .clk     (clk),
    .rst     (rst),
    .clr     (kill),
    .tag_in  (tag_q),
    .tag_out (tag_out)
  );

  assign busy    = (state_q == READ) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign rd_en   = (state_q == READ);
  assign rd_addr = rd_cnt_q;
  assign wr_en   = tag_out[ADDR_W];
  assign wr_addr = tag_out[ADDR_W-1:0];
  assign wr_data = filt_out;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed bench for sobel_frame_sequencer with a 1-cycle frame RAM and a delay-line Sobel filter model.
module tb_sobel_frame_sequencer;
  import sobel_pkg::*;

  localparam int SIZE     = 8;
  localparam int FILT_LAT = 2;
  localparam int ADDR_W   = $clog2(SIZE);
  localparam int ROW_W    = SIZE * PIX_W;
  localparam int OUT_W    = (SIZE - 2) * PIX_W;

  logic              tb_clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ROW_W-1:0]  rd_data;
  logic [ROW_W-1:0]  filt_row;
  logic [OUT_W-1:0]  filt_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [OUT_W-1:0]  wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ROW_W-1:0] mem [SIZE];
  logic [ROW_W-1:0] h1, h2;
  logic [OUT_W-1:0] sob;
  logic [OUT_W-1:0] fpipe [FILT_LAT];

  sobel_frame_sequencer #(
    .SIZE     (SIZE),
    .PIX_W    (PIX_W),
    .FILT_LAT (FILT_LAT),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk      (tb_clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .filt_row (filt_row),
    .filt_out (filt_out),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Frame RAM: data valid one cycle after the read strobe.
  always @(posedge tb_clk) if (rd_en) rd_data <= mem[rd_addr];

  function automatic int px(input logic [ROW_W-1:0] v, input int i);
    return int'(v[i*PIX_W +: PIX_W]);
  endfunction

  // Sobel magnitude |Gx|+|Gy| clamped to 255; t/m/b are the top/middle/bottom rows of the window.
  function automatic logic [OUT_W-1:0] sobel_row(input logic [ROW_W-1:0] t, m, b);
    logic [OUT_W-1:0] r;
    int gx, gy, mag;
    r = '0;
    for (int c = 0; c < SIZE - 2; c++) begin
      gx = (px(t, c+2) + 2*px(m, c+2) + px(b, c+2)) - (px(t, c) + 2*px(m, c) + px(b, c));
      gy = (px(b, c) + 2*px(b, c+1) + px(b, c+2)) - (px(t, c) + 2*px(t, c+1) + px(t, c+2));
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag > 255) mag = 255;
      r[c*PIX_W +: PIX_W] = PIX_W'(mag);
    end
    return r;
  endfunction

  // Filter model: window of the last three rows on filt_row, then FILT_LAT register stages.
  assign sob = sobel_row(h2, h1, filt_row);
  always @(posedge tb_clk) begin
    h1 <= filt_row;
    h2 <= h1;
    fpipe[0] <= sob;
    for (int i = 1; i < FILT_LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign filt_out = fpipe[FILT_LAT-1];

  // img 0: ramp 16*row+col (every output pixel 136); img 1: row*row+col (row k pixels = 16k+24).
  task automatic load_img(input int img);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        mem[r][c*PIX_W +: PIX_W] = (img == 0) ? PIX_W'(16*r + c) : PIX_W'(r*r + c);
  endtask

  function automatic logic [OUT_W-1:0] exp_row(input int img, input int k);
    logic [OUT_W-1:0] r;
    pixel_t p;
    p = (img == 0) ? pixel_t'(136) : pixel_t'(16*k + 24);
    for (int c = 0; c < SIZE - 2; c++) r[c*PIX_W +: PIX_W] = p;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  // One frame whose start was sampled at the end of cycle -1; checks cycles 0..13 against the
  // fixed timing and raises start in the listed cycles (-1 = none).
  task automatic nominal_frame(input int img, input int s_a, input int s_b, input int s_c);
    for (int c = 0; c < 14; c++) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      chk($sformatf("busy c%0d", c), 64'(busy), 64'(c < 12));
      chk($sformatf("done c%0d", c), 64'(done), 64'(c == 12));
      chk($sformatf("rd_en c%0d", c), 64'(rd_en), 64'(c < 8));
      if (c < 8) chk($sformatf("rd_addr c%0d", c), 64'(rd_addr), 64'(c));
      chk($sformatf("wr_en c%0d", c), 64'(wr_en), 64'(c >= 6 && c < 12));
      if (c >= 6 && c < 12) begin
        chk($sformatf("wr_addr c%0d", c), 64'(wr_addr), 64'(c - 6));
        chk($sformatf("wr_data img%0d row%0d", img, c - 6), 64'(wr_data), 64'(exp_row(img, c - 6)));
      end
      start = (c == s_a) || (c == s_b) || (c == s_c);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    load_img(0);
    step();
    step();
    chk("reset ctrl", 64'({busy, done, rd_en, wr_en}), 64'(0));
    chk("reset rd_addr", 64'(rd_addr), 64'(0));
    chk("reset wr_addr", 64'(wr_addr), 64'(0));
    chk("reset filt_row", 64'(filt_row), 64'(0));
    rst = 1'b0;
    step();

    // Basic timing with the ramp image.
    start = 1'b1;
    nominal_frame(0, -1, -1, -1);

    // Starts during busy and during DONE are ignored; start right after done is taken.
    load_img(1);
    start = 1'b1;
    nominal_frame(1, 3, 12, 13);
    nominal_frame(1, -1, -1, -1);

    // Abort in the last read cycle.
    start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      start = 1'b0;
      chk($sformatf("abort rd_addr c%0d", c), 64'(rd_addr), 64'(c));
      if (c == 7) abort = 1'b1;
    end
    for (int c = 8; c < 15; c++) begin
      step();
      abort = 1'b0;
      chk($sformatf("after abort c%0d", c), 64'({busy, done, rd_en, wr_en}), 64'(0));
    end
    load_img(0);
    start = 1'b1;
    nominal_frame(0, -1, -1, -1);

    // Asynchronous reset in the middle of the write phase.
    load_img(1);
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      start = 1'b0;
      chk($sformatf("pre-rst rd_en c%0d", c), 64'(rd_en), 64'(c < 8));
    end
    chk("pre-rst wr_en", 64'(wr_en), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("async rst ctrl", 64'({busy, done, rd_en, wr_en}), 64'(0));
    chk("async rst addrs", 64'({rd_addr, wr_addr}), 64'(0));
    chk("async rst filt_row", 64'(filt_row), 64'(0));
    step();
    rst = 1'b0;
    start = 1'b1;
    nominal_frame(1, -1, -1, -1);

    // abort+start while idle: frame starts.
    load_img(0);
    start = 1'b1;
    abort = 1'b1;
    nominal_frame(0, -1, -1, -1);

    // abort+start while busy: abort only.
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      start = 1'b0;
      chk($sformatf("busy run c%0d", c), 64'(busy), 64'(1));
      if (c == 4) begin
        abort = 1'b1;
        start = 1'b1;
      end
    end
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort+start busy c5", 64'({busy, rd_en}), 64'(0));
    step();
    chk("abort+start busy c6", 64'({busy, rd_en, wr_en, done}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
